bsort_regfile_engine: RTL and testbench

- Parametrised successor to the Bsort 2-read/2-write register file. Keeps the serial shift-in chain, the two indexed write ports and the two indexed read ports.
- Adds an internal bubble-sort sequencer: one compare-and-swap per clock, early exit on a pass with no swaps, selectable sort order, swap counter, and a busy/done handshake.
- Sits between the Bsort data loader and the downstream consumer. The consumer reads results via the A/B ports or the flat bus.

---
 rtl/bsort_regfile_engine.sv | 124 ++++++++++++
 tb/tb_bsort_regfile_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsort_regfile_engine.sv
// rtl/bsort_regfile_engine.sv - 2R/2W register file with shift-in chain and bubble-sort sequencer
module bsort_regfile_engine #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int IDXW   = $clog2(DEPTH),
   parameter bit ASCEND = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_valid,
   input  logic [WIDTH-1:0]         load_data,
   output logic                     load_ready,
   input  logic                     w_en,
   input  logic [IDXW-1:0]          a_idx,
   input  logic [IDXW-1:0]          b_idx,
   input  logic [WIDTH-1:0]         din_a,
   input  logic [WIDTH-1:0]         din_b,
   output logic [WIDTH-1:0]         a_out,
   output logic [WIDTH-1:0]         b_out,
   output logic [DEPTH*WIDTH-1:0]   dout_flat,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [2*IDXW-1:0]        swap_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [IDXW-1:0]  j, j_next, pass_cnt;
   logic             pass_swapped;
   logic [WIDTH-1:0] lo_val, hi_val;
   logic             swap_now, last_j, last_pass, sort_end;

   assign j_next    = j + IDXW'(1);
   assign lo_val    = mem[j];
   assign hi_val    = mem[j_next];
   assign swap_now  = ASCEND ? (lo_val > hi_val) : (lo_val < hi_val);
   assign last_j    = (j == IDXW'(DEPTH - 2));
   assign last_pass = (pass_cnt == IDXW'(DEPTH - 2));
   // A pass ends the sort when it made no swap or it was the final permitted pass.
   assign sort_end  = last_j && (!(pass_swapped || swap_now) || last_pass);

   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            load_ready = 1'b1;
            if (start) state_nxt = S_SORT;
         end
         S_SORT: begin
            busy = 1'b1;
            if (sort_end) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         j            <= '0;
         pass_cnt     <= '0;
         pass_swapped <= 1'b0;
         swap_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  j            <= '0;
                  pass_cnt     <= '0;
                  pass_swapped <= 1'b0;
                  swap_cnt     <= '0;
               end else if (load_valid) begin
                  mem[0] <= load_data;
                  for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
               end else if (w_en) begin
                  // Later assignment gives port B priority on an index collision.
                  mem[a_idx] <= din_a;
                  mem[b_idx] <= din_b;
               end
            end
            S_SORT: begin
               if (swap_now) begin
                  mem[j]      <= hi_val;
                  mem[j_next] <= lo_val;
                  swap_cnt    <= swap_cnt + (2*IDXW)'(1);
               end
               if (last_j) begin
                  j            <= '0;
                  pass_cnt     <= pass_cnt + IDXW'(1);
                  pass_swapped <= 1'b0;
               end else begin
                  j            <= j_next;
                  pass_swapped <= pass_swapped | swap_now;
               end
            end
            default: ;
         endcase
      end
   end

   assign a_out = mem[a_idx];
   assign b_out = mem[b_idx];

   always_comb begin
      dout_flat = '0;
      for (int i = 0; i < DEPTH; i++) dout_flat[i*WIDTH +: WIDTH] = mem[i];
   end

endmodule

// File: tb/tb_bsort_regfile_engine.sv
// tb/tb_bsort_regfile_engine.sv - randomized model-checked bench for ascending and descending instances
module tb_bsort_regfile_engine;
   localparam int W  = 8;
   localparam int D  = 8;
   localparam int IW = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          load_valid, w_en, start;
   logic [W-1:0]  load_data, din_a, din_b;
   logic [IW-1:0] a_idx, b_idx;

   logic          load_ready_i [2];
   logic          busy_i       [2];
   logic          done_i       [2];
   logic [W-1:0]  a_out_i      [2];
   logic [W-1:0]  b_out_i      [2];
   logic [D*W-1:0] flat_i      [2];
   logic [2*IW-1:0] swap_i     [2];

   bsort_regfile_engine #(.WIDTH(W), .DEPTH(D), .ASCEND(1'b1)) u_asc (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready_i[0]), .w_en(w_en), .a_idx(a_idx), .b_idx(b_idx),
      .din_a(din_a), .din_b(din_b), .a_out(a_out_i[0]), .b_out(b_out_i[0]),
      .dout_flat(flat_i[0]), .start(start), .busy(busy_i[0]), .done(done_i[0]),
      .swap_cnt(swap_i[0]));

   bsort_regfile_engine #(.WIDTH(W), .DEPTH(D), .ASCEND(1'b0)) u_dsc (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready_i[1]), .w_en(w_en), .a_idx(a_idx), .b_idx(b_idx),
      .din_a(din_a), .din_b(din_b), .a_out(a_out_i[1]), .b_out(b_out_i[1]),
      .dout_flat(flat_i[1]), .start(start), .busy(busy_i[1]), .done(done_i[1]),
      .swap_cnt(swap_i[1]));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: contents, remaining sort cycles, done flag, swap count per instance.
   int mm    [2][D];
   int fin   [2][D];
   int left  [2];
   bit mdone [2];
   int mswap [2];
   int fswap [2];

   task automatic plan_sort(input int k);
      int a [D];
      int passes, sw, t;
      bit moved, asc;
      asc = (k == 0);
      for (int i = 0; i < D; i++) a[i] = mm[k][i];
      sw = 0;
      for (int i = 0; i < D; i++)
         for (int m = i + 1; m < D; m++)
            if (asc ? (a[i] > a[m]) : (a[i] < a[m])) sw++;
      passes = 0;
      do begin
         moved = 1'b0;
         for (int i = 0; i < D - 1; i++)
            if (asc ? (a[i] > a[i+1]) : (a[i] < a[i+1])) begin
               t = a[i]; a[i] = a[i+1]; a[i+1] = t; moved = 1'b1;
            end
         passes++;
      end while (moved && passes < D - 1);
      for (int i = 0; i < D; i++) fin[k][i] = a[i];
      fswap[k] = sw;
      left[k]  = passes * (D - 1);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < D; i++) mm[k][i] = 0;
            left[k] = 0; mdone[k] = 1'b0; mswap[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (mdone[k]) mdone[k] = 1'b0;
            else if (left[k] > 0) begin
               left[k]--;
               if (left[k] == 0) begin
                  for (int i = 0; i < D; i++) mm[k][i] = fin[k][i];
                  mdone[k] = 1'b1;
                  mswap[k] = fswap[k];
               end
            end else if (start) begin
               plan_sort(k);
               mswap[k] = 0;
            end else if (load_valid) begin
               for (int i = D - 1; i > 0; i--) mm[k][i] = mm[k][i-1];
               mm[k][0] = int'(load_data);
            end else if (w_en) begin
               mm[k][a_idx] = int'(din_a);
               mm[k][b_idx] = int'(din_b);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [D*W-1:0] ef;
      bit eb;
      for (int k = 0; k < 2; k++) begin
         eb = (left[k] > 0);
         chk($sformatf("flags%0d", k), {61'd0, busy_i[k], done_i[k], load_ready_i[k]},
             {61'd0, eb, mdone[k], !eb && !mdone[k]});
         if (!eb) begin
            for (int i = 0; i < D; i++) ef[i*W +: W] = W'(mm[k][i]);
            chk($sformatf("flat%0d", k), flat_i[k], ef);
            chk($sformatf("swap%0d", k), 64'(swap_i[k]), 64'(mswap[k]));
            chk($sformatf("a_out%0d", k), 64'(a_out_i[k]), 64'(mm[k][a_idx]));
            chk($sformatf("b_out%0d", k), 64'(b_out_i[k]), 64'(mm[k][b_idx]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      load_valid = 1'b0; w_en = 1'b0; start = 1'b0;
      load_data = '0; din_a = '0; din_b = '0; a_idx = '0; b_idx = '0;
   endtask

   task automatic run_sort(input bit disturb, output int c0, output int c1);
      int n;
      c0 = 0; c1 = 0; n = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      while (!(load_ready_i[0] && load_ready_i[1]) && n < 200) begin
         if (busy_i[0]) c0++;
         if (busy_i[1]) c1++;
         if (disturb && n == 2) begin
            start = 1'b1; load_valid = 1'b1; w_en = 1'b1;
            load_data = 8'($urandom); din_a = 8'($urandom); din_b = 8'($urandom);
            a_idx = 3'($urandom); b_idx = 3'($urandom);
         end else idle_in();
         cyc();
         n++;
      end
      idle_in();
      if (n >= 200) chk("sort_timeout", 64'(n), 64'd0);
   endtask

   task automatic write_all(input int v0, v1, v2, v3, v4, v5, v6, v7);
      int v [D];
      v = '{v0, v1, v2, v3, v4, v5, v6, v7};
      for (int i = 0; i < D / 2; i++) begin
         w_en = 1'b1; a_idx = 3'(2*i); b_idx = 3'(2*i+1);
         din_a = 8'(v[2*i]); din_b = 8'(v[2*i+1]);
         cyc();
      end
      idle_in();
   endtask

   initial begin
      int c0, c1;
      idle_in();
      #1 rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      chk("rst_ready", 64'(load_ready_i[0]), 64'd1);
      chk("rst_busy",  64'(busy_i[0]), 64'd0);
      chk("rst_flat",  flat_i[1], 64'd0);

      for (int v = 8; v >= 1; v--) begin
         load_valid = 1'b1; load_data = 8'(v);
         cyc();
      end
      idle_in();
      a_idx = 3'd0; b_idx = 3'd7;
      #1;
      chk("shift_a0", 64'(a_out_i[0]), 64'd1);
      chk("shift_b7", 64'(b_out_i[0]), 64'd8);

      run_sort(1'b0, c0, c1);
      chk("sorted_cycles", 64'(c0), 64'd7);
      chk("sorted_swaps",  64'(swap_i[0]), 64'd0);
      chk("sorted_flat",   flat_i[0], 64'h0807060504030201);
      chk("dsc_worst_cycles", 64'(c1), 64'd49);
      chk("dsc_worst_swaps",  64'(swap_i[1]), 64'd28);

      write_all(8, 7, 6, 5, 4, 3, 2, 1);
      run_sort(1'b1, c0, c1);
      chk("worst_cycles", 64'(c0), 64'd49);
      chk("worst_swaps",  64'(swap_i[0]), 64'd28);
      chk("worst_flat",   flat_i[0], 64'h0807060504030201);
      chk("dsc_sorted_cycles", 64'(c1), 64'd7);

      w_en = 1'b1; a_idx = 3'd3; b_idx = 3'd3; din_a = 8'hAA; din_b = 8'h55;
      cyc();
      idle_in();
      a_idx = 3'd3;
      #1;
      chk("conflict_b_wins", 64'(a_out_i[0]), 64'h55);

      w_en = 1'b1; a_idx = 3'd0; din_a = 8'h77; b_idx = 3'd1; din_b = 8'h66;
      load_valid = 1'b1; load_data = 8'h11;
      cyc();
      idle_in();
      a_idx = 3'd0; b_idx = 3'd1;
      #1;
      chk("load_over_wen_a", 64'(a_out_i[0]), 64'h11);
      chk("load_over_wen_b", 64'(b_out_i[0]), 64'h01);

      write_all(5, 5, 9, 1, 2, 3, 4, 6);
      run_sort(1'b1, c0, c1);
      chk("dsc_flat",  flat_i[1], 64'h0102030405050609);
      chk("dsc_swaps", 64'(swap_i[1]), 64'd14);
      chk("asc_flat",  flat_i[0], 64'h0906050504030201);
      chk("asc_swaps", 64'(swap_i[0]), 64'd13);

      repeat (6) begin
         repeat ($urandom_range(4, 12)) begin
            if ($urandom_range(0, 1) == 1) begin
               load_valid = 1'b1; load_data = 8'($urandom_range(0, 15));
            end else begin
               w_en = 1'b1; a_idx = 3'($urandom); b_idx = 3'($urandom);
               din_a = 8'($urandom_range(0, 15)); din_b = 8'($urandom_range(0, 15));
            end
            cyc();
            idle_in();
         end
         run_sort(1'($urandom_range(0, 1)), c0, c1);
      end

      write_all(8, 7, 6, 5, 4, 3, 2, 1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (9) cyc();
      chk("pre_rst_busy", 64'(busy_i[0]), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",  64'(busy_i[0]), 64'd0);
      chk("arst_done",  64'(done_i[0]), 64'd0);
      chk("arst_swap",  64'(swap_i[0]), 64'd0);
      chk("arst_flat",  flat_i[0], 64'd0);
      chk("arst_ready", 64'(load_ready_i[0]), 64'd1);
      cyc();
      rst = 1'b0;
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
